switch_debounce: RTL and testbench



---
 rtl/display_pkg.sv | 38 +++
 rtl/sync_chain.sv | 39 +++
 rtl/switch_debounce.sv | 147 ++++++++++++++
 tb/tb_switch_debounce.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the switch-conditioning and seconds/seg7 display path.
// Contents:
//   db_state_e            - debounce FSM state encoding (2 bits)
//   CLK_HZ                - system clock frequency
//   STABLE_CYCLES_DEFAULT - debounce window in clock cycles (10 ms at CLK_HZ)
//   SEC_TICK_MAX          - seconds-counter compare value (terminal count)
//   seg7_encode()         - BCD digit to active-high gfedcba segment pattern
package display_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_STABLE = 2'd2
    } db_state_e;

    localparam int unsigned CLK_HZ                = 10_000_000;
    localparam int unsigned STABLE_CYCLES_DEFAULT = CLK_HZ / 100;
    localparam int unsigned SEC_TICK_MAX          = CLK_HZ - 1;

    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Per-bit flop chain for bringing asynchronous levels into the clk domain.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high; clears every stage to 0
//   d_i   - asynchronous input vector [WIDTH]
//   q_o   - synchronised output, last stage of the chain [WIDTH]
module sync_chain #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = d_i;
        for (int i = 1; i < int'(STAGES); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(STAGES); i++) begin
            if (reset) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// Switch bank conditioner: synchronises raw_in and debounces it as one vector
// using a single shared stability counter. Any bit change restarts the window.
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high
//   raw_in     - asynchronous switch levels [WIDTH]
//   sw_out     - committed, debounced switch word [WIDTH]
//   sw_valid   - high once the first stable value is committed
//   sw_changed - one-cycle pulse when sw_out takes a new value (not on first commit)
//   sw_rise    - one-cycle per-bit 0->1 pulses at commit [WIDTH]
//   sw_fall    - one-cycle per-bit 1->0 pulses at commit [WIDTH]
module switch_debounce
    import display_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W         = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic             sw_valid,
    output logic             sw_changed,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("switch_debounce: SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 1) begin : g_chk_stable_min
        $error("switch_debounce: STABLE_CYCLES must be at least 1");
    end
    if (64'(STABLE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_chk_cnt_w
        $error("switch_debounce: STABLE_CYCLES does not fit in CNT_W bits");
    end

    // Terminal count of the stability window; reaching it with a matching
    // sample means the candidate has been stable for STABLE_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q;

    sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk   (clk),
        .reset (reset),
        .d_i   (raw_in),
        .q_o   (sync_q)
    );

    db_state_e        state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sw_out_q, sw_out_d;
    logic             sw_valid_q, sw_valid_d;
    logic             sw_changed_q, sw_changed_d;
    logic [WIDTH-1:0] sw_rise_q, sw_rise_d;
    logic [WIDTH-1:0] sw_fall_q, sw_fall_d;
    logic             stable_hit;

    // A mismatch on the would-be commit cycle blocks the commit.
    assign stable_hit = (sync_q == cand_q) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        sw_out_d     = sw_out_q;
        sw_valid_d   = sw_valid_q;
        sw_changed_d = 1'b0;
        sw_rise_d    = '0;
        sw_fall_d    = '0;

        // Candidate tracking runs in every state.
        if (sync_q != cand_q) begin
            cand_d = sync_q;
            cnt_d  = '0;
            if (state_q != ST_INIT) begin
                state_d = ST_SETTLE;
            end
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            ST_INIT: begin
                // First commit publishes the value silently.
                if (stable_hit) begin
                    sw_out_d   = cand_q;
                    sw_valid_d = 1'b1;
                    state_d    = ST_STABLE;
                end
            end
            ST_SETTLE: begin
                if (stable_hit) begin
                    // A bounce that settles back on the old word commits nothing.
                    if (cand_q != sw_out_q) begin
                        sw_out_d     = cand_q;
                        sw_changed_d = 1'b1;
                        sw_rise_d    = cand_q & ~sw_out_q;
                        sw_fall_d    = ~cand_q & sw_out_q;
                    end
                    state_d = ST_STABLE;
                end
            end
            ST_STABLE: begin
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            cand_q       <= '0;
            cnt_q        <= '0;
            sw_out_q     <= '0;
            sw_valid_q   <= 1'b0;
            sw_changed_q <= 1'b0;
            sw_rise_q    <= '0;
            sw_fall_q    <= '0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            sw_out_q     <= sw_out_d;
            sw_valid_q   <= sw_valid_d;
            sw_changed_q <= sw_changed_d;
            sw_rise_q    <= sw_rise_d;
            sw_fall_q    <= sw_fall_d;
        end
    end

    assign sw_out     = sw_out_q;
    assign sw_valid   = sw_valid_q;
    assign sw_changed = sw_changed_q;
    assign sw_rise    = sw_rise_q;
    assign sw_fall    = sw_fall_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with SYNC_STAGES=2, STABLE_CYCLES=4.
// Reference model: raw samples are delayed through a plain array to get the
// synchronised value; a commit happens on the edge where the same
// synchronised value has been seen STABLE_CYCLES+1 times in a row (reset
// preloads one zero sample).
module tb_switch_debounce;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned STABLE = 4;
    localparam int unsigned CNT_W  = 24;
    localparam int LAT = SYNC + STABLE + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] raw_in = '0;
    logic [WIDTH-1:0] sw_out;
    logic             sw_valid;
    logic             sw_changed;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;

    always #5 clk = ~clk;

    switch_debounce #(
        .WIDTH         (WIDTH),
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .CNT_W         (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .sw_out     (sw_out),
        .sw_valid   (sw_valid),
        .sw_changed (sw_changed),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [WIDTH-1:0] m_pipe [SYNC];
    logic [WIDTH-1:0] m_run_val;
    int               m_run_len;
    logic             m_valid;
    logic             m_changed;
    logic [WIDTH-1:0] m_out, m_rise, m_fall;

    // Apply one cycle of stimulus, advance the model, sample 1 ns after the edge.
    task automatic step(input logic [WIDTH-1:0] raw, input logic rst);
        logic [WIDTH-1:0] s;
        raw_in = raw;
        reset  = rst;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < int'(SYNC); i++) m_pipe[i] = '0;
            m_run_val = '0;
            m_run_len = 1;
            m_valid = 1'b0; m_out = '0;
            m_changed = 1'b0; m_rise = '0; m_fall = '0;
        end else begin
            s = m_pipe[SYNC-1];
            m_changed = 1'b0; m_rise = '0; m_fall = '0;
            if (s == m_run_val) begin
                if (m_run_len <= int'(STABLE) + 1) m_run_len++;
            end else begin
                m_run_val = s;
                m_run_len = 1;
            end
            if (m_run_len == int'(STABLE) + 1) begin
                if (!m_valid) begin
                    m_valid = 1'b1;
                    m_out   = m_run_val;
                end else if (m_run_val != m_out) begin
                    m_changed = 1'b1;
                    m_rise    = m_run_val & ~m_out;
                    m_fall    = ~m_run_val & m_out;
                    m_out     = m_run_val;
                end
            end
            for (int i = int'(SYNC) - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = raw;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [25:0] obs, exp;
        int pulses = 0;
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        n_vec++;
        if ({sw_out, sw_valid, sw_changed, sw_rise, sw_fall} !== 26'h0) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h",
                     {sw_out, sw_valid, sw_changed, sw_rise, sw_fall}, 26'h0);
        end
        for (int i = 0; i < 10; i++) begin
            step(8'h00, 1'b0);
            pulses += int'(sw_changed);
            obs = {sw_out, sw_valid, sw_changed, sw_rise, sw_fall};
            exp = {m_out, m_valid, m_changed, m_rise, m_fall};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_model cyc %0d: got %h want %h", i, obs, exp);
            end
        end
        n_vec++;
        if (sw_valid !== 1'b1 || sw_out !== 8'h00 || pulses != 0) begin
            n_err++;
            $display("FAIL reset_first_commit: got valid=%b out=%h pulses=%0d want 1 00 0",
                     sw_valid, sw_out, pulses);
        end
    endtask

    task automatic test_rise();
        logic [25:0] obs, exp;
        int hit = 0;
        int pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            step(8'h05, 1'b0);
            obs = {sw_out, sw_valid, sw_changed, sw_rise, sw_fall};
            exp = {m_out, m_valid, m_changed, m_rise, m_fall};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL rise_model cyc %0d: got %h want %h", i, obs, exp);
            end
            pulses += int'(sw_changed);
            if (hit == 0 && sw_out === 8'h05) begin
                hit = i;
                n_vec++;
                if ({sw_changed, sw_rise, sw_fall} !== {1'b1, 8'h05, 8'h00}) begin
                    n_err++;
                    $display("FAIL rise_pulses: got ch=%b r=%h f=%h want 1 05 00",
                             sw_changed, sw_rise, sw_fall);
                end
            end
        end
        n_vec++;
        if (hit != LAT || pulses != 1) begin
            n_err++;
            $display("FAIL rise_latency: got edge %0d pulses %0d want edge %0d pulses 1",
                     hit, pulses, LAT);
        end
    endtask

    task automatic test_bounce();
        logic [25:0] obs, exp;
        int pulses = 0;
        logic [WIDTH-1:0] r = '0, f = '0;
        for (int i = 0; i < 20; i++) begin
            step(((i / 2) % 2 == 0) ? 8'h04 : 8'h05, 1'b0);
            obs = {sw_out, sw_valid, sw_changed, sw_rise, sw_fall};
            exp = {m_out, m_valid, m_changed, m_rise, m_fall};
            n_vec++;
            if (obs !== exp || sw_out !== 8'h05) begin
                n_err++;
                $display("FAIL bounce_hold cyc %0d: got %h want %h", i, obs, exp);
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(8'h04, 1'b0);
            obs = {sw_out, sw_valid, sw_changed, sw_rise, sw_fall};
            exp = {m_out, m_valid, m_changed, m_rise, m_fall};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL bounce_settle cyc %0d: got %h want %h", i, obs, exp);
            end
            if (sw_changed === 1'b1) begin
                pulses++; r = sw_rise; f = sw_fall;
            end
        end
        n_vec++;
        if (sw_out !== 8'h04 || pulses != 1 || r !== 8'h00 || f !== 8'h01) begin
            n_err++;
            $display("FAIL bounce_commit: got out=%h pulses=%0d r=%h f=%h want 04 1 00 01",
                     sw_out, pulses, r, f);
        end
    endtask

    task automatic test_glitch();
        logic [25:0] obs, exp;
        int pulses = 0;
        for (int i = 0; i < 13; i++) begin
            step((i < 3) ? 8'h84 : 8'h04, 1'b0);
            obs = {sw_out, sw_valid, sw_changed, sw_rise, sw_fall};
            exp = {m_out, m_valid, m_changed, m_rise, m_fall};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL glitch_model cyc %0d: got %h want %h", i, obs, exp);
            end
            pulses += int'(sw_changed) + int'(|sw_rise) + int'(|sw_fall);
        end
        n_vec++;
        if (sw_out !== 8'h04 || pulses != 0) begin
            n_err++;
            $display("FAIL glitch_ignored: got out=%h pulses=%0d want 04 0", sw_out, pulses);
        end
    endtask

    task automatic test_mid_reset();
        logic [25:0] obs, exp;
        int hit = 0;
        int pulses = 0;
        step(8'hFF, 1'b0);
        step(8'hFF, 1'b0);
        step(8'hFF, 1'b1);
        n_vec++;
        if (sw_valid !== 1'b0 || sw_out !== 8'h00) begin
            n_err++;
            $display("FAIL midreset_clear: got valid=%b out=%h want 0 00", sw_valid, sw_out);
        end
        for (int i = 1; i <= 10; i++) begin
            step(8'hFF, 1'b0);
            obs = {sw_out, sw_valid, sw_changed, sw_rise, sw_fall};
            exp = {m_out, m_valid, m_changed, m_rise, m_fall};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL midreset_model cyc %0d: got %h want %h", i, obs, exp);
            end
            pulses += int'(sw_changed);
            if (hit == 0 && sw_valid === 1'b1) hit = i;
        end
        n_vec++;
        if (hit != LAT || sw_out !== 8'hFF || pulses != 0) begin
            n_err++;
            $display("FAIL midreset_recommit: got edge %0d out=%h pulses=%0d want %0d FF 0",
                     hit, sw_out, pulses, LAT);
        end
    endtask

    task automatic test_commit_mismatch();
        logic [25:0] obs, exp;
        int seen10 = 0;
        int pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step((i < 4) ? 8'h10 : 8'h30, 1'b0);
            obs = {sw_out, sw_valid, sw_changed, sw_rise, sw_fall};
            exp = {m_out, m_valid, m_changed, m_rise, m_fall};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL mismatch_model cyc %0d: got %h want %h", i, obs, exp);
            end
            seen10 += int'(sw_out === 8'h10);
            pulses += int'(sw_changed);
        end
        n_vec++;
        if (seen10 != 0 || sw_out !== 8'h30 || pulses != 1) begin
            n_err++;
            $display("FAIL mismatch_commit: got seen10=%0d out=%h pulses=%0d want 0 30 1",
                     seen10, sw_out, pulses);
        end
    endtask

    task automatic test_random();
        logic [25:0] obs, exp;
        logic [WIDTH-1:0] v = 8'h00;
        int i = 0;
        while (i < 600) begin
            int hold = int'($urandom_range(1, 12));
            if ($urandom_range(0, 2) == 0) v = 8'($urandom);
            else v = v ^ 8'(1 << $urandom_range(0, 7));
            for (int j = 0; j < hold && i < 600; j++) begin
                step(v, ($urandom_range(0, 149) == 0));
                obs = {sw_out, sw_valid, sw_changed, sw_rise, sw_fall};
                exp = {m_out, m_valid, m_changed, m_rise, m_fall};
                n_vec++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL random_model cyc %0d: got %h want %h", i, obs, exp);
                end
                i++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_bounce();
        test_glitch();
        test_mid_reset();
        test_commit_mismatch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
